// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB master bridging a valid/ready command port to one APB transfer at a time
// Optional ACCESS wait timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int DW             = 32,
  parameter int AW             = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic [AW-1:0] paddr,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  input  logic          pready,
  input  logic [DW-1:0] prdata,
  input  logic          pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e          state_q, state_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            done;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = busy_q;
    cmd_ready_d = cmd_ready_q;
    done        = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          busy_d      = 1'b1;
          cmd_ready_d = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // Slave response lines only matter on the cycle that pready completes the transfer.
        if (pready) begin
          done        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          done        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d       = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        done = 1'b1;
      end
    endcase
    if (done) begin
      state_d     = IDLE;
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      busy_d      = 1'b0;
      cmd_ready_d = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter DW, default 32, data width of command, response and APB data buses.
REQ-002 SHALL have parameter AW, default 5, address width of command and APB address buses.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS wait cycles (used only when APB_MASTER_TIMEOUT_EN is defined).
REQ-004 SHALL have ports, in this order:
- pclk  input  1  single clock; all state updates on its rising edge.
- presetn  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  AW  target address.
- cmd_wdata  input  DW  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DW  read data; 0 for writes.
- rsp_err  output  1  slave error or timeout.
- busy  output  1  a transfer is in flight (state != IDLE).
- paddr  output  AW  APB address.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- pwdata  output  DW  APB write data.
- pready  input  1  APB slave ready.
- prdata  input  DW  APB read data.
- pslverr  input  1  APB slave error.

Function
REQ-005 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> IDLE, with all outputs registered.
REQ-006 cmd_ready SHALL be 1 only in IDLE. A command is accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-007 On acceptance, the block SHALL capture cmd_write, cmd_addr and cmd_wdata into pwrite, paddr and pwdata, and enter SETUP with psel=1, penable=0.
REQ-008 SETUP SHALL last exactly one cycle, then move to ACCESS with psel=1, penable=1.
REQ-009 paddr, pwrite and pwdata SHALL stay stable from SETUP through the end of ACCESS, and SHALL hold their last values while in IDLE.
REQ-010 ACCESS SHALL repeat while pready=0. When pready=1 is sampled, the next state SHALL be IDLE with psel=0 and penable=0.
REQ-011 On completion, rsp_valid SHALL be 1 for exactly the one cycle after the completing ACCESS cycle.
- rsp_err = sampled pslverr.
- rsp_rdata = sampled prdata for reads, 0 for writes.
REQ-012 Latency with pready tied high: accept at edge T, psel at T+1, penable at T+2, rsp_valid at T+3, next accept no earlier than edge T+3.
REQ-013 rsp_rdata and rsp_err SHALL hold their values until the next completion. rsp_valid SHALL be 0 in all other cycles.
REQ-014 cmd_valid while busy SHALL be ignored. It has no effect on the APB outputs.
REQ-015 pslverr and prdata SHALL be ignored except in the ACCESS cycle where pready=1.

Reset
REQ-016 presetn=0 SHALL asynchronously force IDLE. Output values during reset:
- psel=0, penable=0, pwrite=0.
- paddr=0, pwdata=0.
- rsp_valid=0, rsp_rdata=0, rsp_err=0.
- busy=0, cmd_ready=1.
- Timeout counter=0.
REQ-017 A reset asserted mid-transfer SHALL abort the transfer with no rsp_valid. The first cycle after release SHALL be IDLE.

Configuration
REQ-018 With macro APB_MASTER_TIMEOUT_EN defined:
- A counter SHALL count consecutive ACCESS cycles with pready=0.
- When it reaches TIMEOUT_CYCLES, the next state SHALL be IDLE with psel=0 and penable=0.
- On that abort, rsp_valid=1, rsp_err=1 and rsp_rdata=0.
- The counter SHALL clear on every entry to SETUP.
REQ-019 Without APB_MASTER_TIMEOUT_EN, no counter logic SHALL exist and ACCESS SHALL wait for pready indefinitely.

Verification
REQ-020 Write with pready=1: cmd_addr=0x04, cmd_wdata=0xDEADBEEF -> psel 1 cycle later, penable 2 cycles later with paddr=0x04, pwdata=0xDEADBEEF, pwrite=1; rsp_valid 3 cycles later with rsp_err=0, rsp_rdata=0.
REQ-021 Read with prdata=0x12345678 at completion -> rsp_valid with rsp_rdata=0x12345678 and rsp_err=0. Back-to-back reads are accepted every 3 cycles.
REQ-022 Read with pready held low for 3 ACCESS cycles -> penable high for 4 cycles and paddr stable throughout. cmd_valid pulses during that window are ignored.
REQ-023 Write with pslverr=1 alongside pready=1 -> rsp_err=1 on the rsp_valid cycle, and rsp_err=0 on the following good transfer.
REQ-024 presetn low during ACCESS -> psel and penable drop immediately with no rsp_valid. After release cmd_ready=1 and a new command completes normally.
REQ-025 With APB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=4 and pready stuck at 0 -> ACCESS ends after 4 cycles, then rsp_valid=1 with rsp_err=1 and rsp_rdata=0.
